scan_capture: RTL and testbench

Receive-side counterpart of the row-scanned 8x8 matrix display driver. It watches the driver's column data, active-low row select and frame-done strobe, and rebuilds the full `gs*gs` frame. On every clean scan it publishes the frame as a flat bit vector with a one-cycle valid pulse. It sits between the display driver outputs and any frame checker, or a second consumer such as a mirror display or the verification scoreboard.

---
 rtl/scan_pkg.sv | 8 +
 rtl/scan_capture_if.sv | 16 +
 rtl/scan_row_decode.sv | 21 ++
 rtl/scan_capture.sv | 159 +++++++++++++++
 tb/tb_scan_capture.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan capture block.
package scan_pkg;
  localparam int GS_DEF     = 8;
  localparam int SETTLE_DEF = 4;

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_e;
  typedef enum logic [1:0] {VALID, BLANK, MALFORMED} decode_e;
endpackage

// File: rtl/scan_capture_if.sv
// Display-driver pins in, rebuilt frame and status out.
interface scan_capture_if import scan_pkg::*; #(parameter int gs = GS_DEF);
  logic [gs-1:0]    col_val_i;
  logic [gs-1:0]    row_val_i;
  logic             d_disp_i;
  logic [gs*gs-1:0] matrix_o;
  logic             frame_valid_o;
  logic             busy_o;
  logic             err_o;
  logic [7:0]       frame_cnt_o;

  modport master (output col_val_i, row_val_i, d_disp_i,
                  input  matrix_o, frame_valid_o, busy_o, err_o, frame_cnt_o);
  modport slave  (input  col_val_i, row_val_i, d_disp_i,
                  output matrix_o, frame_valid_o, busy_o, err_o, frame_cnt_o);
endinterface

// File: rtl/scan_row_decode.sv
// Classifies an active-low row select as VALID (with index), BLANK or MALFORMED.
module scan_row_decode import scan_pkg::*; #(
  parameter  int gs = GS_DEF,
  localparam int IW = (gs > 1) ? $clog2(gs) : 1
) (
  input  logic [gs-1:0] row_i,
  output logic [IW-1:0] idx_o,
  output decode_e       kind_o
);
  logic [gs-1:0] sel;
  assign sel = ~row_i;

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < gs; i++)
      if (sel[i]) idx_o = IW'(i);
    if (sel == '0 || sel == '1)                 kind_o = BLANK;
    else if ((sel & (sel - gs'(1))) == '0)      kind_o = VALID;
    else                                        kind_o = MALFORMED;
  end
endmodule

// File: rtl/scan_capture.sv
// Rebuilds a row-scanned matrix frame from driver pins and publishes it on each clean scan.
module scan_capture import scan_pkg::*; #(
  parameter int gs     = GS_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  scan_capture_if.slave bus
);
  localparam int IW = (gs > 1) ? $clog2(gs) : 1;
  localparam int CW = 4;

  logic [gs-1:0]    row_q, col_q, row_p_q, col_p_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [gs*gs-1:0] shadow_q, shadow_d, matrix_q, matrix_d;
  logic [gs-1:0]    mask_q, mask_d, full_n;
  logic [IW-1:0]    exp_q, exp_d, held_r_q, held_r_d, dec_idx;
  logic             held_q, held_d, held_live;
  logic             fv_q, fv_d, busy_q, busy_d, err_q, err_d;
  logic [7:0]       fcnt_q, fcnt_d;
  decode_e          dec_kind;
  logic             row_chg, settle_ev, row_ev, mal_ev, blank_ev, hit;

  scan_row_decode #(.gs(gs)) u_dec (.row_i(row_q), .idx_o(dec_idx), .kind_o(dec_kind));

  always_comb begin
    row_chg   = (row_q != row_p_q);
    cnt_d     = (row_chg || col_q != col_p_q) ? '0 :
                (cnt_q == CW'(SETTLE)) ? cnt_q : cnt_q + CW'(1);
    settle_ev = (cnt_d == CW'(SETTLE - 1));
    // A re-settle of the row already sampled (column wobble) is not a new visit.
    held_live = held_q && !row_chg;
    row_ev    = settle_ev && dec_kind == VALID && !(held_live && dec_idx == held_r_q);
    mal_ev    = settle_ev && dec_kind == MALFORMED;
    blank_ev  = settle_ev && dec_kind == BLANK;

    held_d   = held_live;
    held_r_d = held_r_q;
    if (row_ev) begin
      held_d   = 1'b1;
      held_r_d = dec_idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    exp_d    = exp_q;
    matrix_d = matrix_q;
    fcnt_d   = fcnt_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    hit      = 1'b0;
    full_n   = mask_q;
    case (state_q)
      IDLE: begin
        mask_d = '0;
        exp_d  = '0;
        if (row_ev && dec_idx == '0) begin
          shadow_d[gs-1:0] = col_q;
          mask_d           = gs'(1);
          exp_d            = IW'(1);
          state_d          = CAPTURE;
        end
      end
      CAPTURE: begin
        hit = row_ev && dec_idx == exp_q;
        if (hit) full_n[dec_idx] = 1'b1;
        if ((row_ev && !hit) || mal_ev || (done_q && full_n != '1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (blank_ev) begin
          state_d = IDLE;
        end else begin
          if (hit) begin
            shadow_d[gs*int'(dec_idx) +: gs] = col_q;
            mask_d = full_n;
            exp_d  = exp_q + IW'(1);
          end
          // Last row settling together with done commits immediately.
          if (full_n == '1) begin
            if (done_q) begin
              matrix_d = shadow_d;
              fv_d     = 1'b1;
              fcnt_d   = fcnt_q + 8'd1;
              state_d  = IDLE;
            end else begin
              state_d  = COMMIT;
            end
          end
        end
      end
      COMMIT: begin
        if (row_ev || mal_ev) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (done_q) begin
          matrix_d = shadow_q;
          fv_d     = 1'b1;
          fcnt_d   = fcnt_q + 8'd1;
          state_d  = IDLE;
        end else if (blank_ev) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q    <= '0;
      col_q    <= '0;
      row_p_q  <= '0;
      col_p_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      shadow_q <= '0;
      matrix_q <= '0;
      mask_q   <= '0;
      exp_q    <= '0;
      held_q   <= 1'b0;
      held_r_q <= '0;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      row_q    <= bus.row_val_i;
      col_q    <= bus.col_val_i;
      row_p_q  <= row_q;
      col_p_q  <= col_q;
      done_q   <= bus.d_disp_i;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      matrix_q <= matrix_d;
      mask_q   <= mask_d;
      exp_q    <= exp_d;
      held_q   <= held_d;
      held_r_q <= held_r_d;
      fv_q     <= fv_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign bus.matrix_o      = matrix_q;
  assign bus.frame_valid_o = fv_q;
  assign bus.busy_o        = busy_q;
  assign bus.err_o         = err_q;
  assign bus.frame_cnt_o   = fcnt_q;
endmodule

// File: tb/tb_scan_capture.sv
// Scoreboard bench: stimulus queues expected frame/err events, a monitor pops and compares them.
module tb_scan_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  scan_capture_if #(.gs(8)) bus();
  scan_capture #(.gs(8), .SETTLE(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          is_err;
    int          at;
    logic [63:0] mat;
    logic [7:0]  cnt;
  } ev_t;
  ev_t q[$];
  ev_t e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.frame_valid_o || bus.err_o)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: fv=%b err=%b at cycle %0d", bus.frame_valid_o, bus.err_o, cyc);
      end else begin
        e = q.pop_front();
        chk("ev_kind", {62'd0, bus.err_o, bus.frame_valid_o}, e.is_err ? 64'd2 : 64'd1);
        chk("ev_cycle", 64'(cyc), 64'(e.at));
        if (!e.is_err) begin
          chk("ev_matrix", bus.matrix_o, e.mat);
          chk("ev_cnt", 64'(bus.frame_cnt_o), 64'(e.cnt));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input bit is_err, input int dly, input logic [63:0] m, input logic [7:0] c);
    ev_t x;
    x.is_err = is_err;
    x.at     = cyc + dly;
    x.mat    = m;
    x.cnt    = c;
    q.push_back(x);
  endtask

  task automatic row(input int r, input logic [7:0] c, input int n);
    logic [7:0] one;
    one = 8'h01;
    bus.row_val_i = ~(one << r);
    bus.col_val_i = c;
    tick(n);
  endtask

  task automatic rows(input int lo, input int hi, input logic [7:0] base, input bit add_idx);
    for (int r = lo; r <= hi; r++)
      row(r, add_idx ? base + 8'(r) : base, 20);
  endtask

  task automatic done_pulse();
    bus.d_disp_i = 1'b1;
    tick(1);
    bus.d_disp_i = 1'b0;
  endtask

  task automatic blank(input int n);
    bus.row_val_i = 8'hFF;
    tick(n);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_matrix"}, bus.matrix_o, 64'd0);
    chk({tag, "_fv"},     64'(bus.frame_valid_o), 64'd0);
    chk({tag, "_busy"},   64'(bus.busy_o), 64'd0);
    chk({tag, "_err"},    64'(bus.err_o), 64'd0);
    chk({tag, "_cnt"},    64'(bus.frame_cnt_o), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.row_val_i = 8'hFF;
    bus.col_val_i = 8'h00;
    bus.d_disp_i  = 1'b0;
    tick(3);
    chk_zero("reset");
    rst = 1'b0;
    blank(6);

    // clean scan
    rows(0, 7, 8'hA0, 1'b1);
    expect_ev(1'b0, 2, 64'hA7A6A5A4A3A2A1A0, 8'd1);
    done_pulse();
    blank(10);

    // join mid-frame, then a full scan
    rows(3, 7, 8'h0F, 1'b0);
    done_pulse();
    blank(10);
    rows(0, 7, 8'h0F, 1'b0);
    expect_ev(1'b0, 2, 64'h0F0F0F0F0F0F0F0F, 8'd2);
    done_pulse();
    blank(10);

    // row skip
    row(0, 8'h11, 20);
    row(1, 8'h22, 20);
    chk("skip_busy_before", 64'(bus.busy_o), 64'd1);
    expect_ev(1'b1, 5, 64'd0, 8'd0);
    row(3, 8'h33, 20);
    chk("skip_busy_after", 64'(bus.busy_o), 64'd0);
    chk("skip_matrix_kept", bus.matrix_o, 64'h0F0F0F0F0F0F0F0F);
    blank(10);

    // glitching columns on row 2
    row(0, 8'h01, 20);
    row(1, 8'h02, 20);
    row(2, 8'hAA, 2);
    for (int k = 0; k < 6; k++) row(2, (k % 2 == 0) ? 8'h33 : 8'hAA, 2);
    row(2, 8'h55, 20);
    rows(3, 7, 8'h00, 1'b1);
    expect_ev(1'b0, 2, 64'h0706050403550201, 8'd3);
    done_pulse();
    blank(10);

    // malformed select
    rows(0, 2, 8'h90, 1'b1);
    bus.row_val_i = 8'hFC;
    expect_ev(1'b1, 5, 64'd0, 8'd0);
    tick(10);
    chk("mal_busy", 64'(bus.busy_o), 64'd0);
    blank(10);

    // display blanked mid-frame
    rows(0, 2, 8'h90, 1'b1);
    chk("blank_busy_before", 64'(bus.busy_o), 64'd1);
    blank(10);
    chk("blank_busy_after", 64'(bus.busy_o), 64'd0);
    chk("blank_matrix_kept", bus.matrix_o, 64'h0706050403550201);

    // premature done
    rows(0, 5, 8'h80, 1'b1);
    expect_ev(1'b1, 2, 64'd0, 8'd0);
    done_pulse();
    blank(10);

    // reset mid-frame, then fresh scan
    rows(0, 3, 8'hC0, 1'b1);
    row(4, 8'hC4, 5);
    rst = 1'b1;
    tick(1);
    chk_zero("midrst");
    rst = 1'b0;
    blank(10);
    rows(0, 7, 8'hC0, 1'b1);
    expect_ev(1'b0, 2, 64'hC7C6C5C4C3C2C1C0, 8'd1);
    done_pulse();
    blank(10);

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
